// File: rtl/beat_bpm_detector_if.sv
// beat_bpm_detector_if: frame input and beat/tempo output bundle of the beat detector.
// master = the block feeding FFT frames and consuming beats, slave = the detector.
interface beat_bpm_detector_if;
  logic        enable;
  logic        frame_valid;
  logic [15:0] mag_band0;
  logic [15:0] mag_band1;
  logic        beat_pulse;
  logic [7:0]  bpm_value;
  logic        bpm_valid;
  logic        busy;

  modport master (
    output enable, frame_valid, mag_band0, mag_band1,
    input  beat_pulse, bpm_value, bpm_valid, busy
  );

  modport slave (
    input  enable, frame_valid, mag_band0, mag_band1,
    output beat_pulse, bpm_value, bpm_valid, busy
  );
endinterface

// File: rtl/beat_bpm_detector.sv
// beat_bpm_detector: bass-band beat detector with tempo estimation for the LED
// lighting controller. Per-frame bass energy is compared against an adaptive
// threshold (1.25x running average) with an absolute floor and a refractory
// window; the beat-to-beat interval in ms is turned into BPM by a 16-step
// restoring divider (60000 / interval).
// Build option: define BEAT_SMOOTH_EN to average each new BPM with the previous
// value instead of loading the raw quotient.
module beat_bpm_detector #(
  parameter int          CLK_HZ          = 50_000_000,
  parameter int          AVG_SHIFT       = 3,
  parameter int          THRESH_SHIFT    = 2,
  parameter logic [16:0] MIN_ENERGY      = 17'h00800,
  parameter int          MIN_INTERVAL_MS = 250,
  parameter int          MAX_INTERVAL_MS = 1500
) (
  input logic                clk,
  input logic                rst,
  beat_bpm_detector_if.slave bus
);

  localparam int          PRE_TC       = (CLK_HZ / 1000 > 0) ? CLK_HZ / 1000 : 1;
  localparam int          PRE_W        = (PRE_TC > 1) ? $clog2(PRE_TC) : 1;
  localparam logic [10:0] INTERVAL_SAT = 11'd2047;
  localparam logic [10:0] MIN_IV       = 11'(MIN_INTERVAL_MS);
  localparam logic [10:0] MAX_IV       = 11'(MAX_INTERVAL_MS);
  localparam logic [15:0] BPM_DIVIDEND = 16'd60000;

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  // Front end state
  logic [PRE_W-1:0]   prescaler_reg;
  logic [10:0]        interval_reg;
  logic [10:0]        latched_interval_reg;
  logic [16:0]        avg_reg;
  logic               beat_pulse_reg;

  // Divider / output state
  state_t             state_reg;
  logic [3:0]         div_cnt_reg;
  logic [15:0]        quo_reg;
  logic [10:0]        rem_reg;
  logic [10:0]        divisor_reg;
  logic [7:0]         bpm_value_reg;
  logic               bpm_valid_reg;
  logic               busy_reg;

  // Combinational helpers
  logic               tick;
  logic [PRE_W-1:0]   prescaler_next;
  logic               sample;
  logic [16:0]        energy;
  logic [17:0]        thresh;
  logic               beat_hit;
  logic [10:0]        interval_next;
  logic               timeout;
  logic signed [17:0] avg_diff;
  logic signed [17:0] avg_step;
  logic [16:0]        avg_next;
  logic [11:0]        rem_shift;
  logic               rem_ge;
  logic [10:0]        rem_next;
  logic [7:0]         q_sat;
  logic [7:0]         bpm_done;

  // 1 ms tick from a free-running prescaler (independent of enable)
  assign tick           = (prescaler_reg == PRE_W'(PRE_TC - 1));
  assign prescaler_next = tick ? '0 : prescaler_reg + PRE_W'(1);

  // Energy and adaptive threshold; the compare uses avg before this frame's update
  assign sample   = bus.frame_valid & bus.enable;
  assign energy   = {1'b0, bus.mag_band0} + {1'b0, bus.mag_band1};
  assign thresh   = {1'b0, avg_reg} + ({1'b0, avg_reg} >> THRESH_SHIFT);
  assign beat_hit = sample && ({1'b0, energy} > thresh) &&
                    (energy >= MIN_ENERGY) && (interval_reg >= MIN_IV);

  // Running average: avg += (e - avg) >>> AVG_SHIFT, arithmetic on signed 18b
  assign avg_diff = $signed({1'b0, energy}) - $signed({1'b0, avg_reg});
  assign avg_step = avg_diff >>> AVG_SHIFT;
  assign avg_next = sample ? 17'({1'b0, avg_reg} + avg_step) : avg_reg;

  // Interval: a beat clears it even on a tick; otherwise saturating +1 per ms
  assign interval_next = beat_hit ? 11'd0 :
                         (tick && interval_reg != INTERVAL_SAT) ? interval_reg + 11'd1 :
                         interval_reg;
  // Fires only on the 2046 -> 2047 step, so a saturated interval reports once
  assign timeout = tick && !beat_hit && (interval_reg == INTERVAL_SAT - 11'd1);

  // One restoring-divide step: shift in the next dividend bit, subtract if it fits
  assign rem_shift = {rem_reg, quo_reg[15]};
  assign rem_ge    = (rem_shift >= {1'b0, divisor_reg});
  assign rem_next  = rem_ge ? (rem_shift[10:0] - divisor_reg) : rem_shift[10:0];

  assign q_sat = (|quo_reg[15:8]) ? 8'hFF : quo_reg[7:0];

`ifdef BEAT_SMOOTH_EN
  assign bpm_done = (bpm_value_reg == 8'd0) ? q_sat :
                    8'(({1'b0, bpm_value_reg} + {1'b0, q_sat} + 9'd1) >> 1);
`else
  assign bpm_done = q_sat;
`endif

  // Front end: prescaler, interval counter, running average and beat strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler_reg        <= '0;
      interval_reg         <= INTERVAL_SAT;
      latched_interval_reg <= INTERVAL_SAT;
      avg_reg              <= '0;
      beat_pulse_reg       <= 1'b0;
    end else begin
      prescaler_reg  <= prescaler_next;
      interval_reg   <= interval_next;
      avg_reg        <= avg_next;
      beat_pulse_reg <= beat_hit;
      if (beat_hit) begin
        latched_interval_reg <= interval_reg;
      end
    end
  end

  // Tempo FSM: divide the latched interval into 60000 and publish BPM; timeout overrides
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      div_cnt_reg   <= '0;
      quo_reg       <= '0;
      rem_reg       <= '0;
      divisor_reg   <= '0;
      bpm_value_reg <= '0;
      bpm_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      bpm_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (beat_pulse_reg && latched_interval_reg >= MIN_IV &&
              latched_interval_reg <= MAX_IV) begin
            state_reg   <= DIV;
            busy_reg    <= 1'b1;
            div_cnt_reg <= '0;
            quo_reg     <= BPM_DIVIDEND;
            rem_reg     <= '0;
            divisor_reg <= latched_interval_reg;
          end
        end
        DIV: begin
          quo_reg     <= {quo_reg[14:0], rem_ge};
          rem_reg     <= rem_next;
          div_cnt_reg <= div_cnt_reg + 4'd1;
          if (div_cnt_reg == 4'd15) begin
            state_reg <= DONE;
            busy_reg  <= 1'b0;
          end
        end
        DONE: begin
          bpm_value_reg <= bpm_done;
          bpm_valid_reg <= 1'b1;
          state_reg     <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
      if (timeout) begin
        bpm_value_reg <= 8'd0;
        bpm_valid_reg <= 1'b1;
      end
    end
  end

  assign bus.beat_pulse = beat_pulse_reg;
  assign bus.bpm_value  = bpm_value_reg;
  assign bus.bpm_valid  = bpm_valid_reg;
  assign bus.busy       = busy_reg;

endmodule

// File: tb/tb_beat_bpm_detector.sv
// tb_beat_bpm_detector: directed bench for beat_bpm_detector with CLK_HZ=1000
// (one ms tick per clock). Expected tempos are hand-computed 60000/interval
// values; the smoothed build (BEAT_SMOOTH_EN) has its own expected column.
module tb_beat_bpm_detector;

`ifdef BEAT_SMOOTH_EN
  localparam bit SMOOTH = 1'b1;
`else
  localparam bit SMOOTH = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  beat_bpm_detector_if bus_if ();

  beat_bpm_detector #(
    .CLK_HZ(1000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Observations collected by run()
  int bcnt;
  int vcnt;
  int vt;
  int vval;
  int busy_cnt;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      $display("  ok %s: %0d", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit fv, input logic [16:0] e);
    bus_if.frame_valid = fv;
    bus_if.mag_band0   = 16'(e >> 1);
    bus_if.mag_band1   = 16'(e - (e >> 1));
  endtask

  // One frame; on return beat_pulse reflects that frame
  task automatic frame(input logic [16:0] e);
    drive(1'b1, e);
    step();
    drive(1'b0, 17'd0);
  endtask

  // n cycles of frames (fv=1) or silence (fv=0), recording outputs each cycle
  task automatic run(input int n, input bit fv, input logic [16:0] e);
    bcnt = 0; vcnt = 0; vt = 0; vval = -1; busy_cnt = 0;
    for (int k = 1; k <= n; k++) begin
      drive(fv, e);
      step();
      if (bus_if.beat_pulse) bcnt++;
      if (bus_if.busy) busy_cnt++;
      if (bus_if.bpm_valid) begin
        vcnt++;
        if (vcnt == 1) begin
          vt   = k;
          vval = int'(bus_if.bpm_value);
        end
      end
    end
    drive(1'b0, 17'd0);
  endtask

  initial begin
    bus_if.enable = 1'b1;
    drive(1'b0, 17'd0);
    repeat (3) step();
    check("rst_beat_pulse", 32'(bus_if.beat_pulse), 0);
    check("rst_bpm_value", 32'(bus_if.bpm_value), 0);
    check("rst_bpm_valid", 32'(bus_if.bpm_valid), 0);
    check("rst_busy", 32'(bus_if.busy), 0);
    rst = 1'b0;

    // Quiet frames settle avg, then a loud frame gives the first beat (interval 2047, no BPM)
    run(50, 1'b1, 17'h00100);
    check("quiet_beats", bcnt, 0);
    check("quiet_bpm_valid", vcnt, 0);
    frame(17'h04000);
    check("first_beat", 32'(bus_if.beat_pulse), 1);
    run(500, 1'b1, 17'h00100);
    check("first_beat_single", bcnt, 0);
    check("first_no_bpm", vcnt, 0);
    check("first_no_busy", busy_cnt, 0);

    // Second beat 500 ms later: 120 BPM, 18 cycles after beat, busy 16 cycles
    frame(17'h04000);
    check("beat_500", 32'(bus_if.beat_pulse), 1);
    run(400, 1'b1, 17'h00100);
    check("bpm500_count", vcnt, 1);
    check("bpm500_latency", vt, 18);
    check("bpm500_value", vval, 120);
    check("bpm500_busy_cycles", busy_cnt, 16);
    check("bpm500_single_beat", bcnt, 0);

    // Interval 400 ms -> 150 raw / 135 smoothed; candidate at +10 is refractory
    frame(17'h04000);
    check("beat_400", 32'(bus_if.beat_pulse), 1);
    run(10, 1'b1, 17'h00100);
    frame(17'h04000);
    check("refractory_10", 32'(bus_if.beat_pulse), 0);
    run(300, 1'b1, 17'h00100);
    check("bpm400_count", vcnt, 1);
    check("bpm400_latency", vt, 7);
    check("bpm400_value", vval, SMOOTH ? 135 : 150);
    check("bpm400_no_beat", bcnt, 0);

    // Beat at interval 311 -> 192 raw / 164 smoothed
    frame(17'h04000);
    check("beat_311", 32'(bus_if.beat_pulse), 1);
    run(200, 1'b1, 17'h00100);
    check("bpm311_value", vval, SMOOTH ? 164 : 192);
    check("bpm311_latency", vt, 18);
    // Candidate at 200 ms is refractory, at 260 ms it beats -> 230 raw / 197 smoothed
    frame(17'h04000);
    check("refractory_200", 32'(bus_if.beat_pulse), 0);
    run(59, 1'b1, 17'h00100);
    frame(17'h04000);
    check("beat_260", 32'(bus_if.beat_pulse), 1);
    run(100, 1'b1, 17'h00100);
    check("bpm260_value", vval, SMOOTH ? 197 : 230);
    check("bpm260_count", vcnt, 1);

    // Silence: interval saturates 2047 ms after the last beat -> bpm 0 once
    run(2000, 1'b0, 17'h00000);
    check("timeout_count", vcnt, 1);
    check("timeout_cycle", vt, 1947);
    check("timeout_value", vval, 0);
    run(300, 1'b0, 17'h00000);
    check("timeout_no_repeat", vcnt, 0);
    check("timeout_bpm_held", 32'(bus_if.bpm_value), 0);

    // Energy floor: avg=256, 0x7FF is above threshold but below the floor
    frame(17'h007FF);
    check("floor_below", 32'(bus_if.beat_pulse), 0);
    frame(17'h00800);
    check("floor_at", 32'(bus_if.beat_pulse), 1);

    // Drive avg to exactly 8192 during refractory, then test the strict threshold
    run(100, 1'b1, 17'h10000);
    check("pump_no_bpm", vcnt, 0);
    run(200, 1'b1, 17'h02000);
    check("pump_no_beat", bcnt, 0);
    frame(17'h02800);
    check("thresh_equal", 32'(bus_if.beat_pulse), 0);
    frame(17'h02941);
    check("thresh_pre_update", 32'(bus_if.beat_pulse), 1);
    run(30, 1'b1, 17'h00100);
    check("bpm301_value", vval, 199);
    check("bpm301_latency", vt, 18);

    // Reset in the middle of a divide
    run(469, 1'b1, 17'h00100);
    frame(17'h04000);
    check("beat_pre_rst", 32'(bus_if.beat_pulse), 1);
    run(5, 1'b1, 17'h00100);
    check("busy_mid_div", 32'(bus_if.busy), 1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(bus_if.busy), 0);
    check("mid_rst_bpm_value", 32'(bus_if.bpm_value), 0);
    check("mid_rst_bpm_valid", 32'(bus_if.bpm_valid), 0);
    check("mid_rst_beat_pulse", 32'(bus_if.beat_pulse), 0);
    step();
    rst = 1'b0;
    run(30, 1'b1, 17'h00100);
    check("post_rst_no_bpm", vcnt, 0);
    check("post_rst_no_busy", busy_cnt, 0);
    frame(17'h04000);
    check("post_rst_beat", 32'(bus_if.beat_pulse), 1);
    run(30, 1'b1, 17'h00100);
    check("post_rst_interval_sat", vcnt, 0);

    // Disabled frames are ignored; interval keeps counting (331 ms -> 181)
    bus_if.enable = 1'b0;
    run(300, 1'b0, 17'h00000);
    frame(17'h04000);
    check("disabled_no_beat", 32'(bus_if.beat_pulse), 0);
    bus_if.enable = 1'b1;
    frame(17'h04000);
    check("enabled_beat", 32'(bus_if.beat_pulse), 1);
    run(30, 1'b1, 17'h00100);
    check("bpm331_value", vval, 181);
    check("bpm331_latency", vt, 18);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
